spi_reg_arbiter: RTL and testbench

- Owns the 16x8 configuration register bank written by the SPI slave.
- Shares that bank between two requesters: SPI write commands (addr/data/write-enable from the SPI slave) and a local core port with read/write access via req/gnt handshake.
- SPI writes are edge-captured into a 2-entry pending FIFO; an FSM serialises bank accesses with round-robin arbitration.

---
 rtl/spi_reg_arbiter.sv | 165 ++++++++++++++++
 tb/tb_spi_reg_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_arbiter.sv
// spi_reg_arbiter: configuration register bank shared by an SPI write path and a core
// read/write port. SPI write commands are edge-captured into a small pending FIFO.
// A two-process FSM grants one bank access per two cycles, with round-robin between
// the two requesters.
module spi_reg_arbiter #(
   parameter int unsigned ADDR_W     = 4,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned FIFO_DEPTH = 2,
   localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              spi_we,
   input  logic [ADDR_W-1:0] spi_addr,
   input  logic [DATA_W-1:0] spi_data,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_gnt,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,
   output logic              spi_overflow,
   input  logic              clear_ovf,
   output logic [CNT_W-1:0]  spi_pending,
   output logic [DATA_W-1:0] ctrl_reg0
);

   localparam int unsigned NUM_REGS = 2 ** ADDR_W;
   localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StSpiWr, StCoreAcc} state_e;

   state_e            state_q, state_d;
   logic              rr_last_core_q, rr_last_core_d;  // 1: core had the last access
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              spi_we_q;
   logic              ovf_q;
   logic              rvalid_q;
   logic [DATA_W-1:0] rdata_q;

   logic spi_rise, fifo_full, fifo_nonempty, push_ok, push_drop, pop;

   assign spi_rise      = spi_we & ~spi_we_q;
   assign fifo_full     = (count_q == FULL_CNT);
   assign fifo_nonempty = (count_q != '0);
   // A pop in the same cycle frees a slot, so a push onto a full FIFO is kept then.
   assign push_ok       = spi_rise & (~fifo_full | pop);
   assign push_drop     = spi_rise & fifo_full & ~pop;

   // Arbitration: next state, round-robin pointer and grant/pop strobes.
   always_comb begin
      state_d        = state_q;
      rr_last_core_d = rr_last_core_q;
      core_gnt       = 1'b0;
      pop            = 1'b0;
      case (state_q)
         StIdle: begin
            if (fifo_nonempty && core_req) begin
               state_d = rr_last_core_q ? StSpiWr : StCoreAcc;
            end else if (fifo_nonempty) begin
               state_d = StSpiWr;
            end else if (core_req) begin
               state_d = StCoreAcc;
            end
         end
         StSpiWr: begin
            pop            = 1'b1;
            rr_last_core_d = 1'b0;
            state_d        = StIdle;
         end
         StCoreAcc: begin
            core_gnt       = 1'b1;
            rr_last_core_d = 1'b1;
            state_d        = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM state, round-robin pointer, SPI edge detect and sticky overflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= StIdle;
         rr_last_core_q <= 1'b0;
         spi_we_q       <= 1'b0;
         ovf_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         rr_last_core_q <= rr_last_core_d;
         spi_we_q       <= spi_we;
         // Set has priority over a coincident clear.
         if (push_drop) begin
            ovf_q <= 1'b1;
         end else if (clear_ovf) begin
            ovf_q <= 1'b0;
         end
      end
   end

   // Pending SPI write FIFO: storage, pointers and occupancy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            fifo_addr_q[i] <= '0;
            fifo_data_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            fifo_addr_q[wr_ptr_q] <= spi_addr;
            fifo_data_q[wr_ptr_q] <= spi_data;
            wr_ptr_q              <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push_ok && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push_ok) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   // Register bank: one writer per cycle, chosen by the FSM state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs_q[i] <= '0;
         end
      end else if (pop) begin
         regs_q[fifo_addr_q[rd_ptr_q]] <= fifo_data_q[rd_ptr_q];
      end else if (core_gnt && core_we) begin
         regs_q[core_addr] <= core_wdata;
      end
   end

   // Core read return: data held until the next read, valid pulsed once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= core_gnt & ~core_we;
         if (core_gnt && !core_we) begin
            rdata_q <= regs_q[core_addr];
         end
      end
   end

   assign core_rvalid  = rvalid_q;
   assign core_rdata   = rdata_q;
   assign spi_overflow = ovf_q;
   assign spi_pending  = count_q;
   assign ctrl_reg0    = regs_q[0];

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// tb_spi_reg_arbiter: directed scenarios plus randomized traffic, every cycle compared
// against a queue/array reference model of the arbiter's rules.
module tb_spi_reg_arbiter;

   logic       clk        = 1'b0;
   logic       reset_n    = 1'b0;
   logic       spi_we     = 1'b0;
   logic [3:0] spi_addr   = '0;
   logic [7:0] spi_data   = '0;
   logic       core_req   = 1'b0;
   logic       core_we    = 1'b0;
   logic [3:0] core_addr  = '0;
   logic [7:0] core_wdata = '0;
   logic       clear_ovf  = 1'b0;
   logic       core_gnt, core_rvalid, spi_overflow;
   logic [7:0] core_rdata, ctrl_reg0;
   logic [1:0] spi_pending;

   always #5 clk = ~clk;

   spi_reg_arbiter #(.ADDR_W(4), .DATA_W(8), .FIFO_DEPTH(2)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .spi_we       (spi_we),
      .spi_addr     (spi_addr),
      .spi_data     (spi_data),
      .core_req     (core_req),
      .core_we      (core_we),
      .core_addr    (core_addr),
      .core_wdata   (core_wdata),
      .core_gnt     (core_gnt),
      .core_rvalid  (core_rvalid),
      .core_rdata   (core_rdata),
      .spi_overflow (spi_overflow),
      .clear_ovf    (clear_ovf),
      .spi_pending  (spi_pending),
      .ctrl_reg0    (ctrl_reg0)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: bank array, pending queue, and the access scheduled for the
   // current cycle (0 none, 1 SPI write, 2 core access).
   logic [7:0]  m_regs [16];
   logic [11:0] m_q [$];
   bit          m_ovf, m_we_prev, m_rvalid, m_last_core, m_core_done;
   logic [7:0]  m_rdata;
   int          m_sched;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_q.delete();
      m_ovf       = 0;
      m_we_prev   = 0;
      m_rvalid    = 0;
      m_last_core = 0;
      m_core_done = 0;
      m_rdata     = '0;
      m_sched     = 0;
   endtask

   // Advance the model across one rising edge using the inputs present at that edge.
   task automatic model_step();
      logic [11:0] e;
      bit          nonempty, rise;
      int          nxt;
      if (!reset_n) begin
         model_reset();
         return;
      end
      nonempty    = (m_q.size() != 0);
      nxt         = 0;
      m_rvalid    = 0;
      m_core_done = 0;
      if (m_sched == 1) begin
         e = m_q.pop_front();
         m_regs[e[11:8]] = e[7:0];
         m_last_core = 0;
      end else if (m_sched == 2) begin
         if (core_we) m_regs[core_addr] = core_wdata;
         else begin
            m_rdata  = m_regs[core_addr];
            m_rvalid = 1;
         end
         m_last_core = 1;
         m_core_done = 1;
      end else if (nonempty && core_req) nxt = m_last_core ? 1 : 2;
      else if (nonempty) nxt = 1;
      else if (core_req) nxt = 2;
      rise = spi_we && !m_we_prev;
      if (clear_ovf) m_ovf = 0;
      if (rise) begin
         if (m_q.size() < 2) m_q.push_back({spi_addr, spi_data});
         else m_ovf = 1;
      end
      m_we_prev = spi_we;
      m_sched   = nxt;
   endtask

   task automatic check_outputs();
      check_eq("core_gnt", core_gnt, m_sched == 2);
      check_eq("core_rvalid", core_rvalid, m_rvalid);
      check_eq("core_rdata", core_rdata, m_rdata);
      check_eq("spi_overflow", spi_overflow, m_ovf);
      check_eq("spi_pending", spi_pending, m_q.size());
      check_eq("ctrl_reg0", ctrl_reg0, m_regs[0]);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      spi_we   = 0;
      core_req = 0;
      clear_ovf = 0;
      reset_n  = 0;
      repeat (2) tick();
      reset_n  = 1;
      tick();
   endtask

   task automatic spi_pulse(input logic [3:0] a, input logic [7:0] d, input int len);
      spi_we   = 1;
      spi_addr = a;
      spi_data = d;
      repeat (len) tick();
      spi_we = 0;
      tick();
   endtask

   // Issue one core access and return once it has completed (bounded wait).
   task automatic core_access(input logic we, input logic [3:0] a, input logic [7:0] d);
      int n    = 0;
      bit seen = 0;
      core_req   = 1;
      core_we    = we;
      core_addr  = a;
      core_wdata = d;
      while (!seen && n < 20) begin
         tick();
         n++;
         if (core_gnt) seen = 1;
      end
      check_eq("core_gnt_within_bound", seen, 1);
      tick();
      core_req = 0;
   endtask

   initial begin
      int  spi_left = 0;
      int  spi_gap  = 0;
      int  n;
      bit  found;
      model_reset();

      // Reset values
      do_reset();
      check_eq("rst_pending", spi_pending, 0);
      check_eq("rst_ovf", spi_overflow, 0);
      check_eq("rst_rvalid", core_rvalid, 0);
      check_eq("rst_rdata", core_rdata, 0);
      check_eq("rst_ctrl_reg0", ctrl_reg0, 0);

      // SPI write addr 3, then core read back
      spi_pulse(4'd3, 8'hA5, 4);
      repeat (2) tick();
      check_eq("spi3_drained", spi_pending, 0);
      core_access(1'b0, 4'd3, 8'h00);
      check_eq("rd3_rvalid", core_rvalid, 1);
      check_eq("rd3_data", core_rdata, 8'hA5);

      // Core write to register 0
      core_access(1'b1, 4'd0, 8'h5C);
      check_eq("wr0_ctrl_reg0", ctrl_reg0, 8'h5C);
      check_eq("wr0_no_rvalid", core_rvalid, 0);

      // Both requesters right after reset: core first, SPI write to same address lands last
      do_reset();
      spi_we = 1; spi_addr = 4'd7; spi_data = 8'h99;
      core_req = 1; core_we = 1; core_addr = 4'd7; core_wdata = 8'h33;
      tick();
      check_eq("tie_core_first", core_gnt, 1);
      check_eq("tie_spi_waiting", spi_pending, 1);
      tick();
      core_req = 0;
      spi_we   = 0;
      repeat (3) tick();
      check_eq("tie_drained", spi_pending, 0);
      core_access(1'b0, 4'd7, 8'h00);
      check_eq("rd7_last_writer", core_rdata, 8'h99);

      // Overflow while the core keeps requesting; clear coincident with a drop must lose
      core_req = 1; core_we = 0; core_addr = 4'd8;
      found = 0;
      n = 0;
      while (!found && n < 20) begin
         spi_we   = 1;
         spi_addr = 4'($urandom_range(1, 6));
         spi_data = 8'($urandom);
         if (m_q.size() == 2 && m_sched != 1) begin
            clear_ovf = 1;
            found     = 1;
         end
         tick();
         if (found) check_eq("ovf_set_wins", spi_overflow, 1);
         clear_ovf = 0;
         spi_we    = 0;
         tick();
         n++;
      end
      check_eq("ovf_sticky", spi_overflow, 1);
      core_req  = 0;
      clear_ovf = 1;
      tick();
      clear_ovf = 0;
      check_eq("ovf_cleared", spi_overflow, 0);
      repeat (8) tick();

      // Reset asserted during a core write grant: write must not land
      core_req = 1; core_we = 1; core_addr = 4'd5; core_wdata = 8'h77;
      n = 0;
      while (!core_gnt && n < 10) begin
         tick();
         n++;
      end
      check_eq("rst_mid_gnt_seen", core_gnt, 1);
      #2 reset_n = 0;
      #1;
      model_reset();
      check_outputs();
      check_eq("rst_mid_gnt_low", core_gnt, 0);
      core_req = 0;
      tick();
      reset_n = 1;
      tick();
      check_eq("rst_mid_fifo_empty", spi_pending, 0);
      core_access(1'b0, 4'd5, 8'h00);
      check_eq("rst_mid_reg5", core_rdata, 0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (spi_we) begin
            spi_left--;
            if (spi_left <= 0) begin
               spi_we  = 0;
               spi_gap = $urandom_range(1, 6);
            end
         end else begin
            if (spi_gap > 0) spi_gap--;
            if (spi_gap == 0 && $urandom_range(0, 1) == 1) begin
               spi_we   = 1;
               spi_addr = 4'($urandom_range(0, 7));
               spi_data = 8'($urandom);
               spi_left = $urandom_range(1, 5);
            end
         end
         if (!core_req || m_core_done) begin
            core_req   = ($urandom_range(0, 3) != 0);
            core_we    = 1'($urandom_range(0, 1));
            core_addr  = 4'($urandom_range(0, 15));
            core_wdata = 8'($urandom);
         end
         clear_ovf = ($urandom_range(0, 7) == 0);
      end
      spi_we    = 0;
      core_req  = 0;
      clear_ovf = 0;
      repeat (10) tick();

      // Read back the whole bank against the model
      for (int a = 0; a < 16; a++) begin
         core_access(1'b0, 4'(a), 8'h00);
         check_eq("bank_readback", core_rdata, m_regs[a]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
